bp_perf_counters: RTL and testbench

Parametrised branch-prediction performance counter block for the pipelined RISC-V cores. It accumulates cycle, instruction, branch and misprediction counts for NUM_CH predictor channels, so several predictors can be compared in one run. It supports free-running or fixed-window measurement, optional saturation, and a req/ack snapshot interface. It sits in the top-level bench wrapper, fed by each core's flush (miss), EX-jump (branch) and fetch-valid strobes.

---
 rtl/bp_perf_counters.sv | 135 +++++++++++++
 tb/tb_bp_perf_counters.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bp_perf_counters.sv
// Branch-prediction performance counters: cycle, instruction, per-channel branch and
// misprediction counts with optional saturation, fixed-window auto-snapshot and req/ack snapshot.
module bp_perf_counters #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32,
    parameter int WINDOW = 0,
    parameter int SAT    = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      en_i,
    input  logic                      clear_i,
    input  logic                      instr_valid_i,
    input  logic [NUM_CH-1:0]         br_instr_i,
    input  logic [NUM_CH-1:0]         br_miss_i,
    input  logic                      snap_req_i,
    output logic                      snap_ack_o,
    output logic                      win_done_o,
    output logic                      ovf_o,
    output logic [CNT_W-1:0]          cyc_o,
    output logic [CNT_W-1:0]          instr_o,
    output logic [NUM_CH*CNT_W-1:0]   br_o,
    output logic [NUM_CH*CNT_W-1:0]   miss_o
);

    localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW + 1) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'((WINDOW > 0) ? WINDOW - 1 : 0);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state_q, state_d;

    logic [CNT_W-1:0] cyc_q, instr_q;
    logic [CNT_W-1:0] br_q   [NUM_CH];
    logic [CNT_W-1:0] miss_q [NUM_CH];
    logic [WIN_W-1:0] win_q;

    logic [CNT_W:0] bump_cyc, bump_instr;
    logic [CNT_W:0] bump_br   [NUM_CH];
    logic [CNT_W:0] bump_miss [NUM_CH];

    logic counting, win_hit, snap_take, ovf_evt;

    // Result MSB flags a saturate/wrap event; lower bits are the next counter value.
    function automatic logic [CNT_W:0] bump(input logic [CNT_W-1:0] v, input logic inc);
        if (!inc)
            return {1'b0, v};
        if (&v)
            return (SAT != 0) ? {1'b1, v} : {1'b1, {CNT_W{1'b0}}};
        return {1'b0, v + CNT_W'(1)};
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en_i)  state_d = RUN;
            RUN:     if (!en_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The cycle in which en_i rises is already counted, so count on the next-state.
    assign counting  = (state_d == RUN);
    assign win_hit   = (WINDOW > 0) && counting && (win_q == WIN_LAST);
    assign snap_take = snap_req_i && !snap_ack_o;

    always_comb begin
        bump_cyc   = bump(cyc_q, counting);
        bump_instr = bump(instr_q, counting & instr_valid_i);
        ovf_evt    = bump_cyc[CNT_W] | bump_instr[CNT_W];
        for (int c = 0; c < NUM_CH; c++) begin
            bump_br[c]   = bump(br_q[c], counting & br_instr_i[c]);
            bump_miss[c] = bump(miss_q[c], counting & br_instr_i[c] & br_miss_i[c]);
            ovf_evt      = ovf_evt | bump_br[c][CNT_W] | bump_miss[c][CNT_W];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cyc_q      <= '0;
            instr_q    <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                br_q[c]   <= '0;
                miss_q[c] <= '0;
            end
            win_q      <= '0;
            snap_ack_o <= 1'b0;
            win_done_o <= 1'b0;
            ovf_o      <= 1'b0;
            cyc_o      <= '0;
            instr_o    <= '0;
            br_o       <= '0;
            miss_o     <= '0;
        end else begin
            state_q    <= state_d;
            snap_ack_o <= snap_req_i;
            win_done_o <= win_hit;

            // Snapshots see this cycle's events even when a clear lands in the same cycle.
            if (snap_take || win_hit) begin
                cyc_o   <= bump_cyc[CNT_W-1:0];
                instr_o <= bump_instr[CNT_W-1:0];
                for (int c = 0; c < NUM_CH; c++) begin
                    br_o[c*CNT_W +: CNT_W]   <= bump_br[c][CNT_W-1:0];
                    miss_o[c*CNT_W +: CNT_W] <= bump_miss[c][CNT_W-1:0];
                end
            end

            if (clear_i || win_hit) begin
                cyc_q   <= '0;
                instr_q <= '0;
                for (int c = 0; c < NUM_CH; c++) begin
                    br_q[c]   <= '0;
                    miss_q[c] <= '0;
                end
                win_q   <= '0;
            end else begin
                cyc_q   <= bump_cyc[CNT_W-1:0];
                instr_q <= bump_instr[CNT_W-1:0];
                for (int c = 0; c < NUM_CH; c++) begin
                    br_q[c]   <= bump_br[c][CNT_W-1:0];
                    miss_q[c] <= bump_miss[c][CNT_W-1:0];
                end
                if (counting)
                    win_q <= win_q + WIN_W'(1);
            end

            if (clear_i)
                ovf_o <= 1'b0;
            else if (ovf_evt)
                ovf_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bp_perf_counters.sv
// Directed bench for bp_perf_counters: default, 8-bit saturating, 8-bit wrapping and
// 16-cycle window instances share one stimulus stream.
module tb_bp_perf_counters;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_i, en_i, clear_i, instr_valid_i, snap_req_i;
    logic [1:0] br_instr_i, br_miss_i;

    logic        a_ack, a_win, a_ovf;
    logic [31:0] a_cyc, a_instr;
    logic [63:0] a_br, a_miss;

    logic        s_ack, s_win, s_ovf;
    logic [7:0]  s_cyc, s_instr;
    logic [15:0] s_br, s_miss;

    logic        w_ack, w_win, w_ovf;
    logic [7:0]  w_cyc, w_instr;
    logic [15:0] w_br, w_miss;

    logic        n_ack, n_win, n_ovf;
    logic [31:0] n_cyc, n_instr;
    logic [63:0] n_br, n_miss;

    int pass_cnt  = 0;
    int total_cnt = 0;

    bp_perf_counters u_dflt (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .clear_i(clear_i),
        .instr_valid_i(instr_valid_i), .br_instr_i(br_instr_i), .br_miss_i(br_miss_i),
        .snap_req_i(snap_req_i), .snap_ack_o(a_ack), .win_done_o(a_win), .ovf_o(a_ovf),
        .cyc_o(a_cyc), .instr_o(a_instr), .br_o(a_br), .miss_o(a_miss)
    );

    bp_perf_counters #(.CNT_W(8), .SAT(1)) u_sat (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .clear_i(clear_i),
        .instr_valid_i(instr_valid_i), .br_instr_i(br_instr_i), .br_miss_i(br_miss_i),
        .snap_req_i(snap_req_i), .snap_ack_o(s_ack), .win_done_o(s_win), .ovf_o(s_ovf),
        .cyc_o(s_cyc), .instr_o(s_instr), .br_o(s_br), .miss_o(s_miss)
    );

    bp_perf_counters #(.CNT_W(8), .SAT(0)) u_wrap (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .clear_i(clear_i),
        .instr_valid_i(instr_valid_i), .br_instr_i(br_instr_i), .br_miss_i(br_miss_i),
        .snap_req_i(snap_req_i), .snap_ack_o(w_ack), .win_done_o(w_win), .ovf_o(w_ovf),
        .cyc_o(w_cyc), .instr_o(w_instr), .br_o(w_br), .miss_o(w_miss)
    );

    bp_perf_counters #(.WINDOW(16)) u_win (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .clear_i(clear_i),
        .instr_valid_i(instr_valid_i), .br_instr_i(br_instr_i), .br_miss_i(br_miss_i),
        .snap_req_i(snap_req_i), .snap_ack_o(n_ack), .win_done_o(n_win), .ovf_o(n_ovf),
        .cyc_o(n_cyc), .instr_o(n_instr), .br_o(n_br), .miss_o(n_miss)
    );

    // Inputs change 1 time unit after a rising edge; control returns 1 unit after the n-th edge.
    task automatic applyStimulus(input logic en, input logic instr, input logic [1:0] br,
                                 input logic [1:0] miss, input logic req, input logic clr,
                                 input int n);
        en_i          = en;
        instr_valid_i = instr;
        br_instr_i    = br;
        br_miss_i     = miss;
        snap_req_i    = req;
        clear_i       = clr;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic doReset();
        rst_i = 1'b1;
        applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1);
        rst_i = 1'b0;
    endtask

    initial begin
        doReset();
        checkOutput("rst_cyc",   a_cyc, 0);
        checkOutput("rst_instr", a_instr, 0);
        checkOutput("rst_br",    a_br, 0);
        checkOutput("rst_miss",  a_miss, 0);
        checkOutput("rst_ack",   a_ack, 0);
        checkOutput("rst_ovf",   a_ovf, 0);
        checkOutput("rst_wdone", n_win, 0);

        $display("[TB] basic counting");
        applyStimulus(1'b1, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1);
        checkOutput("p1_ack",     a_ack, 1);
        checkOutput("p1_cyc",     a_cyc, 10);
        checkOutput("p1_instr",   a_instr, 10);
        checkOutput("p1_br_ch0",  a_br[31:0], 10);
        checkOutput("p1_br_ch1",  a_br[63:32], 0);
        checkOutput("p1_miss",    a_miss, 0);
        applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1);
        checkOutput("p1_ack_fall", a_ack, 0);

        $display("[TB] qualified misses");
        applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1);
        applyStimulus(1'b1, 1'b0, 2'b10, 2'b11, 1'b0, 1'b0, 5);
        applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1);
        checkOutput("p2_cyc",      a_cyc, 5);
        checkOutput("p2_instr",    a_instr, 0);
        checkOutput("p2_br_ch0",   a_br[31:0], 0);
        checkOutput("p2_br_ch1",   a_br[63:32], 5);
        checkOutput("p2_miss_ch0", a_miss[31:0], 0);
        checkOutput("p2_miss_ch1", a_miss[63:32], 5);
        applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1);

        $display("[TB] saturate and wrap");
        doReset();
        applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 300);
        applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1);
        checkOutput("p3_sat_cyc",  s_cyc, 255);
        checkOutput("p3_sat_ovf",  s_ovf, 1);
        checkOutput("p3_wrap_cyc", w_cyc, 44);
        checkOutput("p3_wrap_ovf", w_ovf, 1);
        checkOutput("p3_dflt_cyc", a_cyc, 300);
        checkOutput("p3_dflt_ovf", a_ovf, 0);
        applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1);
        checkOutput("p3_sat_ovf_clr",  s_ovf, 0);
        checkOutput("p3_wrap_ovf_clr", w_ovf, 0);
        checkOutput("p3_sat_cyc_kept", s_cyc, 255);
        applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1);

        $display("[TB] window with idle gap");
        doReset();
        applyStimulus(1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 8);
        applyStimulus(1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 4);
        applyStimulus(1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 7);
        checkOutput("p4_wdone_early", n_win, 0);
        applyStimulus(1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1);
        checkOutput("p4_wdone",     n_win, 1);
        checkOutput("p4_win_cyc",   n_cyc, 16);
        checkOutput("p4_win_instr", n_instr, 16);
        applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1);
        checkOutput("p4_wdone_pulse", n_win, 0);
        applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2);
        applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1);
        checkOutput("p4_restart_cyc", n_cyc, 3);
        applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1);

        $display("[TB] snapshot with clear, held request");
        doReset();
        applyStimulus(1'b1, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 6);
        applyStimulus(1'b1, 1'b1, 2'b01, 2'b00, 1'b1, 1'b1, 1);
        checkOutput("p5_ack",     a_ack, 1);
        checkOutput("p5_cyc",     a_cyc, 7);
        checkOutput("p5_instr",   a_instr, 7);
        checkOutput("p5_br_ch0",  a_br[31:0], 7);
        applyStimulus(1'b1, 1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 5);
        checkOutput("p5_ack_held", a_ack, 1);
        checkOutput("p5_one_snap", a_cyc, 7);
        applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1);
        checkOutput("p5_ack_fall", a_ack, 0);
        applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1);
        checkOutput("p5_post_clear_cyc", a_cyc, 5);
        checkOutput("p5_win_snap_cyc",   n_cyc, 5);

        $display("[TB] asynchronous reset mid-handshake");
        applyStimulus(1'b1, 1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 1);
        #2 rst_i = 1'b1;
        #1;
        checkOutput("p6_ack",     a_ack, 0);
        checkOutput("p6_cyc",     a_cyc, 0);
        checkOutput("p6_instr",   a_instr, 0);
        checkOutput("p6_br",      a_br, 0);
        checkOutput("p6_win_cyc", n_cyc, 0);
        checkOutput("p6_wdone",   n_win, 0);
        #1 rst_i = 1'b0;
        applyStimulus(1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 2);
        applyStimulus(1'b0, 1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 1);
        checkOutput("p6_idle_ack",   a_ack, 1);
        checkOutput("p6_idle_instr", a_instr, 0);
        checkOutput("p6_idle_br",    a_br, 0);
        applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
